// File: rtl/data_memory_if.sv
// Bus interface between the datapath and data_memory.
// DMEM_STATS_EN adds the load_count/store_count statistics signals.
interface data_memory_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] read_data;
    logic        busy;
    logic        misaligned;
`ifdef DMEM_STATS_EN
    logic [31:0] load_count;
    logic [31:0] store_count;
`endif

    modport master (
        output addr, write_data, mem_read, mem_write, size, sign_ext,
        input  read_data, busy, misaligned
`ifdef DMEM_STATS_EN
        , input load_count, store_count
`endif
    );

    modport slave (
        input  addr, write_data, mem_read, mem_write, size, sign_ext,
        output read_data, busy, misaligned
`ifdef DMEM_STATS_EN
        , output load_count, store_count
`endif
    );
endinterface

// File: rtl/data_memory.sv
// Word-organised MIPS data memory: combinational loads, clocked stores,
// byte/half/word lanes, misalignment suppression and a clear-after-reset FSM.
// Optional macro DMEM_STATS_EN adds accepted load/store counters.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   CLEAR | zeroing one word per cycle from clr_idx, busy=1
//   READY | normal load/store service, busy=0
module data_memory #(
    parameter  int DEPTH_WORDS = 256,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    data_memory_if.slave  bus
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    state_t             state;
    logic [IDX_W-1:0]   clr_idx;
    logic               busy_q;
    logic [31:0]        mem [DEPTH_WORDS];

    logic [IDX_W-1:0]   idx;
    logic [1:0]         lane;
    logic [31:0]        word_rd;
    logic               req;
    logic               mis_c;
    logic               load_ok;
    logic               store_ok;
    logic [31:0]        rdata;
    logic [31:0]        wmask;
    logic [31:0]        wdata;
    logic [7:0]         byte_v;
    logic [15:0]        half_v;

    // Address bits above the word index wrap and are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[31:IDX_W+2];

    assign idx     = bus.addr[IDX_W+1:2];
    assign lane    = bus.addr[1:0];
    assign word_rd = mem[idx];
    assign req     = bus.mem_read | bus.mem_write;

    // Alignment check; only meaningful once the clear has finished.
    always_comb begin
        mis_c = 1'b0;
        if (!busy_q && req) begin
            case (bus.size)
                2'b01:   mis_c = bus.addr[0];
                2'b10:   mis_c = (lane != 2'b00);
                2'b11:   mis_c = 1'b1;
                default: mis_c = 1'b0;
            endcase
        end
    end

    assign load_ok  = !busy_q && bus.mem_read  && !mis_c;
    assign store_ok = !busy_q && bus.mem_write && !mis_c;

    // Load path: lane select and sign/zero extension.
    always_comb begin
        rdata  = '0;
        byte_v = '0;
        half_v = '0;
        case (lane)
            2'd0:    byte_v = word_rd[7:0];
            2'd1:    byte_v = word_rd[15:8];
            2'd2:    byte_v = word_rd[23:16];
            default: byte_v = word_rd[31:24];
        endcase
        half_v = bus.addr[1] ? word_rd[31:16] : word_rd[15:0];
        if (load_ok) begin
            case (bus.size)
                2'b00:   rdata = bus.sign_ext ? {{24{byte_v[7]}}, byte_v}
                                              : {24'h000000, byte_v};
                2'b01:   rdata = bus.sign_ext ? {{16{half_v[15]}}, half_v}
                                              : {16'h0000, half_v};
                2'b10:   rdata = word_rd;
                default: rdata = '0;
            endcase
        end
    end

    // Store path: replicate the source into every lane, then mask.
    always_comb begin
        wmask = '0;
        wdata = '0;
        case (bus.size)
            2'b00: begin
                wmask = 32'h0000_00FF << {lane, 3'b000};
                wdata = {4{bus.write_data[7:0]}};
            end
            2'b01: begin
                wmask = bus.addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wdata = {2{bus.write_data[15:0]}};
            end
            2'b10: begin
                wmask = 32'hFFFF_FFFF;
                wdata = bus.write_data;
            end
            default: begin
                wmask = '0;
                wdata = '0;
            end
        endcase
    end

    // Clear FSM and array update; reset restarts the clear from word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    mem[clr_idx] <= '0;
                    clr_idx      <= clr_idx + 1'b1;
                    if (clr_idx == LAST_IDX) begin
                        state  <= READY;
                        busy_q <= 1'b0;
                    end
                end
                READY: begin
                    if (store_ok) begin
                        mem[idx] <= (word_rd & ~wmask) | (wdata & wmask);
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_idx <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.read_data  = rdata;
    assign bus.busy       = busy_q;
    assign bus.misaligned = mis_c;

`ifdef DMEM_STATS_EN
    logic [31:0] load_cnt_q;
    logic [31:0] store_cnt_q;

    // Accepted-access counters; free-running wrap at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            if (load_ok)  load_cnt_q  <= load_cnt_q + 32'd1;
            if (store_ok) store_cnt_q <= store_cnt_q + 32'd1;
        end
    end

    assign bus.load_count  = load_cnt_q;
    assign bus.store_count = store_cnt_q;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: reset/clear timing, lane access,
// misalignment, wrap, reset during clear, and optional statistics counters.
module tb_data_memory;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    typedef struct packed {
        logic [31:0] rd;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_memory_if bus ();
    data_memory #(.DEPTH_WORDS(256)) dut (.clk(clk), .reset(reset), .bus(bus));

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.size       = SZ_W;
        bus.sign_ext   = 1'b0;
        bus.addr       = '0;
        bus.write_data = '0;
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                                input logic sx, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rd, input logic exp_mis);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.sx = sx; v.addr = addr;
        v.wdata = wdata; v.exp_rd = exp_rd; v.exp_mis = exp_mis;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int n);
        exp_t e;
        @(negedge clk);
        bus.mem_read   = v.rd;
        bus.mem_write  = v.wr;
        bus.size       = v.size;
        bus.sign_ext   = v.sx;
        bus.addr       = v.addr;
        bus.write_data = v.wdata;
        sb.push_back('{rd: v.exp_rd, mis: v.exp_mis});
        #1;
        e = sb.pop_front();
        chk($sformatf("vec%0d read_data", n), bus.read_data, e.rd);
        chk($sformatf("vec%0d misaligned", n), {31'd0, bus.misaligned}, {31'd0, e.mis});
        @(posedge clk);
        #1;
        idle();
    endtask

    // Called just after reset is released; counts cycles with busy high.
    task automatic wait_clear(input int exp_cycles, input bit hammer);
        int n = 0;
        while (bus.busy === 1'b1 && n < 1000) begin
            n++;
            if (hammer) begin
                bus.mem_read   = 1'b1;
                bus.mem_write  = 1'b1;
                bus.size       = SZ_W;
                bus.addr       = 32'h0;
                bus.write_data = 32'hFFFF_FFFF;
                #1;
                chk("busy read_data", bus.read_data, 32'h0);
                chk("busy misaligned", {31'd0, bus.misaligned}, 32'h0);
            end
            @(negedge clk);
            #1;
        end
        idle();
        chk("clear busy cycles", n, exp_cycles);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        bus.mem_read = 1'b1;
        bus.size     = SZ_X;
        bus.addr     = 32'h41;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset busy", {31'd0, bus.busy}, 32'h1);
        chk("reset read_data", bus.read_data, 32'h0);
        chk("reset misaligned", {31'd0, bus.misaligned}, 32'h0);
        idle();
        reset = 1'b0;
        wait_clear(256, 1'b0);

        vecs.push_back(mk(1, 0, SZ_W, 0, 32'h000, 32'h0,          32'h0000_0000, 0));
        vecs.push_back(mk(1, 0, SZ_W, 0, 32'h3FC, 32'h0,          32'h0000_0000, 0));
        vecs.push_back(mk(0, 1, SZ_W, 0, 32'h010, 32'h1122_3344,  32'h0000_0000, 0));
        vecs.push_back(mk(0, 1, SZ_B, 0, 32'h012, 32'h1234_56AA,  32'h0000_0000, 0));
        vecs.push_back(mk(1, 0, SZ_W, 0, 32'h010, 32'h0,          32'h11AA_3344, 0));
        vecs.push_back(mk(1, 0, SZ_B, 1, 32'h012, 32'h0,          32'hFFFF_FFAA, 0));
        vecs.push_back(mk(1, 0, SZ_B, 0, 32'h012, 32'h0,          32'h0000_00AA, 0));
        vecs.push_back(mk(0, 1, SZ_H, 0, 32'h022, 32'hABCD_8001,  32'h0000_0000, 0));
        vecs.push_back(mk(1, 0, SZ_W, 0, 32'h020, 32'h0,          32'h8001_0000, 0));
        vecs.push_back(mk(1, 0, SZ_H, 1, 32'h022, 32'h0,          32'hFFFF_8001, 0));
        vecs.push_back(mk(1, 0, SZ_H, 0, 32'h022, 32'h0,          32'h0000_8001, 0));
        vecs.push_back(mk(0, 1, SZ_W, 0, 32'h041, 32'hDEAD_BEEF,  32'h0000_0000, 1));
        vecs.push_back(mk(1, 0, SZ_W, 0, 32'h040, 32'h0,          32'h0000_0000, 0));
        vecs.push_back(mk(1, 0, SZ_H, 1, 32'h043, 32'h0,          32'h0000_0000, 1));
        vecs.push_back(mk(1, 0, SZ_X, 0, 32'h010, 32'h0,          32'h0000_0000, 1));
        vecs.push_back(mk(0, 1, SZ_H, 0, 32'h021, 32'h0000_5555,  32'h0000_0000, 1));
        vecs.push_back(mk(1, 0, SZ_W, 0, 32'h020, 32'h0,          32'h8001_0000, 0));
        vecs.push_back(mk(0, 1, SZ_X, 0, 32'h050, 32'hFFFF_FFFF,  32'h0000_0000, 1));
        vecs.push_back(mk(1, 0, SZ_W, 0, 32'h050, 32'h0,          32'h0000_0000, 0));
        vecs.push_back(mk(0, 1, SZ_W, 0, 32'h400, 32'h0000_0005,  32'h0000_0000, 0));
        vecs.push_back(mk(1, 0, SZ_W, 0, 32'h000, 32'h0,          32'h0000_0005, 0));
        vecs.push_back(mk(1, 1, SZ_W, 0, 32'h010, 32'hCAFE_F00D,  32'h11AA_3344, 0));
        vecs.push_back(mk(1, 0, SZ_W, 0, 32'h010, 32'h0,          32'hCAFE_F00D, 0));
        vecs.push_back(mk(0, 0, SZ_W, 0, 32'h010, 32'h0,          32'h0000_0000, 0));
        vecs.push_back(mk(1, 0, SZ_B, 1, 32'h011, 32'h0,          32'hFFFF_FFF0, 0));
        vecs.push_back(mk(1, 0, SZ_B, 0, 32'h013, 32'h0,          32'h0000_00CA, 0));
        vecs.push_back(mk(0, 1, SZ_H, 0, 32'h010, 32'h9999_1234,  32'h0000_0000, 0));
        vecs.push_back(mk(1, 0, SZ_W, 0, 32'h010, 32'h0,          32'hCAFE_1234, 0));
        vecs.push_back(mk(1, 0, SZ_H, 1, 32'h012, 32'h0,          32'hFFFF_CAFE, 0));
        vecs.push_back(mk(1, 0, SZ_H, 0, 32'h010, 32'h0,          32'h0000_1234, 0));

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset 100 cycles into a clear, with stores hammering word 0 while busy.
        pulse_reset();
        repeat (100) @(negedge clk);
        #1;
        chk("mid-clear busy", {31'd0, bus.busy}, 32'h1);
        pulse_reset();
        wait_clear(256, 1'b1);
        run_vec(mk(1, 0, SZ_W, 0, 32'h000, 32'h0, 32'h0000_0000, 0), 100);
        run_vec(mk(1, 0, SZ_W, 0, 32'h010, 32'h0, 32'h0000_0000, 0), 101);

`ifdef DMEM_STATS_EN
        run_vec(mk(1, 0, SZ_W, 0, 32'h000, 32'h0, 32'h0, 0), 200);
        pulse_reset();
        chk("stats reset load_count", bus.load_count, 32'h0);
        chk("stats reset store_count", bus.store_count, 32'h0);
        wait_clear(256, 1'b0);
        chk("stats clear load_count", bus.load_count, 32'h0);
        run_vec(mk(1, 0, SZ_W, 0, 32'h000, 32'h0,         32'h0000_0000, 0), 201);
        run_vec(mk(1, 0, SZ_B, 0, 32'h008, 32'h0,         32'h0000_0000, 0), 202);
        run_vec(mk(1, 1, SZ_W, 0, 32'h010, 32'h0000_0077, 32'h0000_0000, 0), 203);
        run_vec(mk(0, 1, SZ_H, 0, 32'h020, 32'h0000_1111, 32'h0000_0000, 0), 204);
        run_vec(mk(0, 1, SZ_W, 0, 32'h041, 32'hDEAD_BEEF, 32'h0000_0000, 1), 205);
        @(negedge clk);
        #1;
        chk("stats load_count", bus.load_count, 32'd3);
        chk("stats store_count", bus.store_count, 32'd2);
        pulse_reset();
        chk("stats reset2 load_count", bus.load_count, 32'h0);
        chk("stats reset2 store_count", bus.store_count, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
